// File: rtl/inst_queue_pkg.sv
// Shared widths and entry type for the fetch-to-decode instruction queue.
// The ID1/ID2 stages use the same PC and instruction widths.
package inst_queue_pkg;

  localparam int INST_W   = 32;
  localparam int PC_W     = 32;
  localparam int IQ_DEPTH = 16;
  localparam int IQ_PTR_W = 4;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } iq_entry_t;

  // Requested pop count; a second-slot pop without the first is meaningless.
  function automatic logic [1:0] req_pops(input logic r_ena_1, input logic r_ena_2);
    return r_ena_1 ? (r_ena_2 ? 2'd2 : 2'd1) : 2'd0;
  endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Fetch/issue side bundle of the instruction queue.
// master = fetch + issue logic, slave = the queue itself.
interface inst_queue_if #(
  parameter int PTR_W = inst_queue_pkg::IQ_PTR_W
);
  import inst_queue_pkg::*;

  logic              flush;
  logic              w_ena_1;
  logic              w_ena_2;
  logic [PC_W-1:0]   w_pc_1;
  logic [PC_W-1:0]   w_pc_2;
  logic [INST_W-1:0] w_inst_1;
  logic [INST_W-1:0] w_inst_2;
  logic              r_ena_1;
  logic              r_ena_2;
  logic              q_valid_1;
  logic              q_valid_2;
  logic [PC_W-1:0]   q_pc_1;
  logic [PC_W-1:0]   q_pc_2;
  logic [INST_W-1:0] q_inst_1;
  logic [INST_W-1:0] q_inst_2;
  logic              full;
  logic              empty;
  logic [PTR_W:0]    count;

  modport master (
    output flush, w_ena_1, w_ena_2, w_pc_1, w_pc_2, w_inst_1, w_inst_2,
           r_ena_1, r_ena_2,
    input  q_valid_1, q_valid_2, q_pc_1, q_pc_2, q_inst_1, q_inst_2,
           full, empty, count
  );

  modport slave (
    input  flush, w_ena_1, w_ena_2, w_pc_1, w_pc_2, w_inst_1, w_inst_2,
           r_ena_1, r_ena_2,
    output q_valid_1, q_valid_2, q_pc_1, q_pc_2, q_inst_1, q_inst_2,
           full, empty, count
  );

endinterface

// File: rtl/inst_queue_ram.sv
// 2-write / 2-read register array holding {pc, inst} entries.
// Reads are asynchronous; the two write addresses are never equal when both are enabled.
module inst_queue_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int PTR_W = IQ_PTR_W
) (
  input  logic             clk,
  input  logic             we_1,
  input  logic [PTR_W-1:0] waddr_1,
  input  iq_entry_t        wdata_1,
  input  logic             we_2,
  input  logic [PTR_W-1:0] waddr_2,
  input  iq_entry_t        wdata_2,
  input  logic [PTR_W-1:0] raddr_1,
  input  logic [PTR_W-1:0] raddr_2,
  output iq_entry_t        rdata_1,
  output iq_entry_t        rdata_2
);

  iq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_1) mem_q[waddr_1] <= wdata_1;
    if (we_2) mem_q[waddr_2] <= wdata_2;
  end

  assign rdata_1 = mem_q[raddr_1];
  assign rdata_2 = mem_q[raddr_2];

endmodule

// File: rtl/inst_queue.sv
// Dual-push / dual-pop in-order instruction queue between fetch and ID1.
// Pointer and occupancy control lives here; storage is in inst_queue_ram.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int PTR_W = IQ_PTR_W
) (
  input  logic         clk,
  input  logic         rst,
  inst_queue_if.slave  qif
);

  localparam logic [PTR_W:0] FULL_TH = (PTR_W+1)'(DEPTH - 2);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   cnt_q,  cnt_d;

  logic             full_w;
  logic             accept_w;
  logic [1:0]       nw_w;
  logic [1:0]       nr_req_w;
  logic [1:0]       nr_w;

  logic             we_1, we_2;
  logic [PTR_W-1:0] waddr_2;
  iq_entry_t        wdata_1, wdata_2;
  iq_entry_t        rdata_1, rdata_2;

  assign full_w   = (cnt_q > FULL_TH);
  // A pop in the same cycle does not reopen the queue: full is registered state only.
  assign accept_w = ~full_w;
  assign nw_w     = accept_w ? ({1'b0, qif.w_ena_1} + {1'b0, qif.w_ena_2}) : 2'd0;
  assign nr_req_w = req_pops(qif.r_ena_1, qif.r_ena_2);
  assign nr_w     = ((PTR_W+1)'(nr_req_w) > cnt_q) ? cnt_q[1:0] : nr_req_w;

  always_comb begin
    head_d = head_q + PTR_W'(nr_w);
    tail_d = tail_q + PTR_W'(nw_w);
    cnt_d  = cnt_q + (PTR_W+1)'(nw_w) - (PTR_W+1)'(nr_w);
    if (rst || qif.flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
    cnt_q  <= cnt_d;
  end

  // Slot 2 compacts down to tail when slot 1 is idle.
  assign we_1    = accept_w & qif.w_ena_1 & ~qif.flush & ~rst;
  assign we_2    = accept_w & qif.w_ena_2 & ~qif.flush & ~rst;
  assign waddr_2 = qif.w_ena_1 ? (tail_q + PTR_W'(1)) : tail_q;
  assign wdata_1 = '{pc: qif.w_pc_1, inst: qif.w_inst_1};
  assign wdata_2 = '{pc: qif.w_pc_2, inst: qif.w_inst_2};

  inst_queue_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we_1    (we_1),
    .waddr_1 (tail_q),
    .wdata_1 (wdata_1),
    .we_2    (we_2),
    .waddr_2 (waddr_2),
    .wdata_2 (wdata_2),
    .raddr_1 (head_q),
    .raddr_2 (head_q + PTR_W'(1)),
    .rdata_1 (rdata_1),
    .rdata_2 (rdata_2)
  );

  assign qif.q_valid_1 = (cnt_q != '0);
  assign qif.q_valid_2 = (cnt_q > (PTR_W+1)'(1));
  assign qif.q_pc_1    = qif.q_valid_1 ? rdata_1.pc   : '0;
  assign qif.q_inst_1  = qif.q_valid_1 ? rdata_1.inst : '0;
  assign qif.q_pc_2    = qif.q_valid_2 ? rdata_2.pc   : '0;
  assign qif.q_inst_2  = qif.q_valid_2 ? rdata_2.inst : '0;
  assign qif.full      = full_w;
  assign qif.empty     = (cnt_q == '0);
  assign qif.count     = cnt_q;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: fill/drop, pop order, pointer wrap, simultaneous
// push/pop and flush, with hand-computed expected head contents.
module tb_inst_queue;
  import inst_queue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  inst_queue_if #(.PTR_W(4)) qif ();

  inst_queue #(
    .DEPTH (16),
    .PTR_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .qif (qif)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  // One clock: drive inputs, take the edge, release inputs 1 time unit later.
  task automatic cyc(input logic w1, input logic w2, input logic [31:0] pc1,
                     input logic [31:0] pc2, input logic r1, input logic r2,
                     input logic fl);
    qif.w_ena_1  = w1;
    qif.w_ena_2  = w2;
    qif.w_pc_1   = pc1;
    qif.w_pc_2   = pc2;
    qif.w_inst_1 = inst_of(pc1);
    qif.w_inst_2 = inst_of(pc2);
    qif.r_ena_1  = r1;
    qif.r_ena_2  = r2;
    qif.flush    = fl;
    @(posedge clk);
    #1;
    qif.w_ena_1 = 1'b0;
    qif.w_ena_2 = 1'b0;
    qif.r_ena_1 = 1'b0;
    qif.r_ena_2 = 1'b0;
    qif.flush   = 1'b0;
    $display("txn rst=%b w=%b%b pc=%h/%h r=%b%b flush=%b -> count=%0d v=%b%b q_pc=%h/%h",
             rst, w1, w2, pc1, pc2, r1, r2, fl, qif.count, qif.q_valid_1,
             qif.q_valid_2, qif.q_pc_1, qif.q_pc_2);
  endtask

  task automatic check_head(input string tag, input logic v1, input logic v2,
                            input logic [31:0] p1, input logic [31:0] p2, input int c);
    chk({tag, ".valid_1"}, 32'(qif.q_valid_1), 32'(v1));
    chk({tag, ".valid_2"}, 32'(qif.q_valid_2), 32'(v2));
    chk({tag, ".pc_1"},    qif.q_pc_1, p1);
    chk({tag, ".pc_2"},    qif.q_pc_2, p2);
    chk({tag, ".count"},   32'(qif.count), 32'(c));
  endtask

  initial begin
    qif.flush    = 1'b0;
    qif.w_ena_1  = 1'b0;
    qif.w_ena_2  = 1'b0;
    qif.w_pc_1   = '0;
    qif.w_pc_2   = '0;
    qif.w_inst_1 = '0;
    qif.w_inst_2 = '0;
    qif.r_ena_1  = 1'b0;
    qif.r_ena_2  = 1'b0;
    #2;

    // Reset, including flush and writes during reset.
    cyc(1'b1, 1'b1, 32'h111, 32'h222, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 32'h333, 32'h444, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check_head("rst", 1'b0, 1'b0, 32'h0, 32'h0, 0);
    chk("rst.full",   32'(qif.full), 32'd0);
    chk("rst.empty",  32'(qif.empty), 32'd1);
    chk("rst.inst_1", qif.q_inst_1, 32'h0);

    // First dual push.
    cyc(1'b1, 1'b1, 32'h1000, 32'h1004, 1'b0, 1'b0, 1'b0);
    check_head("push", 1'b1, 1'b1, 32'h1000, 32'h1004, 2);
    chk("push.inst_1", qif.q_inst_1, inst_of(32'h1000));
    chk("push.inst_2", qif.q_inst_2, inst_of(32'h1004));
    chk("push.empty",  32'(qif.empty), 32'd0);

    // Fill to DEPTH-2 (full still low), then one more pair fills exactly.
    for (int k = 1; k <= 6; k++)
      cyc(1'b1, 1'b1, 32'h1000 + 32'(8 * k), 32'h1004 + 32'(8 * k), 1'b0, 1'b0, 1'b0);
    chk("fill14.count", 32'(qif.count), 32'd14);
    chk("fill14.full",  32'(qif.full), 32'd0);
    cyc(1'b1, 1'b1, 32'h1038, 32'h103C, 1'b0, 1'b0, 1'b0);
    check_head("fill16", 1'b1, 1'b1, 32'h1000, 32'h1004, 16);
    chk("fill16.full", 32'(qif.full), 32'd1);

    // Write while full with a same-cycle pop: write dropped, pop taken.
    cyc(1'b1, 1'b1, 32'hDEAD0000, 32'hDEAD0004, 1'b1, 1'b0, 1'b0);
    check_head("drop", 1'b1, 1'b1, 32'h1004, 32'h1008, 15);
    chk("drop.full", 32'(qif.full), 32'd1);

    // Drain down to three entries (head = 13).
    for (int k = 0; k < 6; k++)
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    check_head("pop3", 1'b1, 1'b1, 32'h1034, 32'h1038, 3);
    chk("pop3.full", 32'(qif.full), 32'd0);

    // r_ena_2 without r_ena_1 is ignored.
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    check_head("r2only", 1'b1, 1'b1, 32'h1034, 32'h1038, 3);

    // Dual pop leaves one entry; second slot gated to zero.
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    check_head("pop2", 1'b1, 1'b0, 32'h103C, 32'h0, 1);
    chk("pop2.inst_2", qif.q_inst_2, 32'h0);

    // head = 15: second head slot reads entry 0.
    cyc(1'b1, 1'b0, 32'h3000, 32'h0, 1'b0, 1'b0, 1'b0);
    check_head("hwrap", 1'b1, 1'b1, 32'h103C, 32'h3000, 2);
    chk("hwrap.inst_2", qif.q_inst_2, inst_of(32'h3000));

    // Drain, then pop on empty has no effect.
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    check_head("popempty", 1'b0, 1'b0, 32'h0, 32'h0, 0);
    chk("popempty.empty", 32'(qif.empty), 32'd1);

    // Move head = tail = 15 from a flushed queue.
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++)
      cyc(1'b1, 1'b1, 32'h5000 + 32'(8 * k), 32'h5004 + 32'(8 * k), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'h5038, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("pre_wrap.count", 32'(qif.count), 32'd15);
    for (int k = 0; k < 7; k++)
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    check_head("pre_wrap.last", 1'b1, 1'b0, 32'h5038, 32'h0, 1);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("pre_wrap.empty", 32'(qif.empty), 32'd1);

    // Tail wrap: pair lands at 15 and 0.
    cyc(1'b1, 1'b1, 32'h2000, 32'h2004, 1'b0, 1'b0, 1'b0);
    check_head("twrap", 1'b1, 1'b1, 32'h2000, 32'h2004, 2);

    // Build five entries, then push 2 + pop 2 together.
    cyc(1'b1, 1'b1, 32'h2008, 32'h200C, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'h2010, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("pre_simul.count", 32'(qif.count), 32'd5);
    cyc(1'b1, 1'b1, 32'h2014, 32'h2018, 1'b1, 1'b1, 1'b0);
    check_head("simul", 1'b1, 1'b1, 32'h2008, 32'h200C, 5);

    // Flush at cnt = 7 with writes and a pop in the same cycle.
    cyc(1'b1, 1'b1, 32'h201C, 32'h2020, 1'b0, 1'b0, 1'b0);
    chk("pre_flush.count", 32'(qif.count), 32'd7);
    cyc(1'b1, 1'b1, 32'h6000, 32'h6004, 1'b1, 1'b0, 1'b1);
    check_head("flush", 1'b0, 1'b0, 32'h0, 32'h0, 0);
    chk("flush.empty",  32'(qif.empty), 32'd1);
    chk("flush.inst_1", qif.q_inst_1, 32'h0);

    // Slot 2 alone is written at tail and shows up in head slot 1.
    cyc(1'b0, 1'b1, 32'h0, 32'h4000, 1'b0, 1'b0, 1'b0);
    check_head("slot2", 1'b1, 1'b0, 32'h4000, 32'h0, 1);
    chk("slot2.inst_1", qif.q_inst_1, inst_of(32'h4000));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
